// File: rtl/xbar_route_ctrl.sv
// xbar_route_ctrl: searches the 32 settings of a five-switch 4x4 network for one
// that delivers the requested source to each output, then registers that setting
// as the crossbar control word.
// Optional build macro: XBAR_ROUTE_CTRL_CACHE_EN adds a one-entry cache of the
// last successfully routed request so that a repeat request is answered at once.
module xbar_route_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_src,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_err,
  output logic [4:0] control
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] src_q, src_d;
  logic [4:0] ctrl_q, ctrl_d;
  logic       err_q, err_d;

`ifdef XBAR_ROUTE_CTRL_CACHE_EN
  logic       cache_v_q, cache_v_d;
  logic [7:0] cache_src_q, cache_src_d;
  logic [4:0] cache_ctrl_q, cache_ctrl_d;
`endif

  // Push the four input labels through the switch network for setting c and
  // report whether every output receives the source the request asks for.
  function automatic logic route_match(input logic [4:0] c, input logic [7:0] src);
    logic [1:0] t1, t2, t3, t4, t5, t6;
    logic [1:0] o1, o2, o3, o4;
    t1 = c[0] ? 2'd1 : 2'd0;
    t2 = c[0] ? 2'd0 : 2'd1;
    t4 = c[3] ? 2'd3 : 2'd2;
    t6 = c[3] ? 2'd2 : 2'd3;
    t3 = c[2] ? t4 : t2;
    t5 = c[2] ? t2 : t4;
    o1 = c[1] ? t3 : t1;
    o2 = c[1] ? t1 : t3;
    o3 = c[4] ? t6 : t5;
    o4 = c[4] ? t5 : t6;
    return ({o4, o3, o2, o1} == src);
  endfunction

  // A request naming the same input for two outputs can never be routed.
  function automatic logic has_dup(input logic [7:0] src);
    return (src[1:0] == src[3:2]) || (src[1:0] == src[5:4]) ||
           (src[1:0] == src[7:6]) || (src[3:2] == src[5:4]) ||
           (src[3:2] == src[7:6]) || (src[5:4] == src[7:6]);
  endfunction

  // Next-state logic: accept, search one candidate per cycle, hold the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
`ifdef XBAR_ROUTE_CTRL_CACHE_EN
    cache_v_d    = cache_v_q;
    cache_src_d  = cache_src_q;
    cache_ctrl_d = cache_ctrl_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d = req_src;
          cnt_d = 5'd0;
          if (has_dup(req_src)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end
`ifdef XBAR_ROUTE_CTRL_CACHE_EN
          else if (cache_v_q && (cache_src_q == req_src)) begin
            state_d = RESP;
            ctrl_d  = cache_ctrl_q;
            err_d   = 1'b0;
          end
`endif
          else begin
            state_d = SEARCH;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (route_match(cnt_q, src_q)) begin
          state_d = RESP;
          ctrl_d  = cnt_q;
          err_d   = 1'b0;
`ifdef XBAR_ROUTE_CTRL_CACHE_EN
          cache_v_d    = 1'b1;
          cache_src_d  = src_q;
          cache_ctrl_d = cnt_q;
`endif
        end else if (cnt_q == 5'd31) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          cnt_d   = 5'd0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State register; reset abandons any search or pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      src_q   <= 8'd0;
      ctrl_q  <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

`ifdef XBAR_ROUTE_CTRL_CACHE_EN
  // Cache register; reset invalidates it, only successful searches refill it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_v_q    <= 1'b0;
      cache_src_q  <= 8'd0;
      cache_ctrl_q <= 5'd0;
    end else begin
      cache_v_q    <= cache_v_d;
      cache_src_q  <= cache_src_d;
      cache_ctrl_q <= cache_ctrl_d;
    end
  end
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  assign control    = ctrl_q;

endmodule

// File: doc/xbar_route_ctrl.md
XBAR_ROUTE_CTRL -- requirements
Module: xbar_route_ctrl

Interface
REQ-001 The block SHALL run on one clock and use an asynchronous, active-low reset.
REQ-002 The block SHALL have no parameters.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  routing request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_src  input  8  source per output: [1:0]=out1, [3:2]=out2, [5:4]=out3, [7:6]=out4; value 0..3 selects in1..in4.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer accepts result.
REQ-010 resp_err  output  1  request unroutable, qualified by resp_valid.
REQ-011 control  output  5  registered control word for the downstream 4x4 4-bit crossbar.

Function
REQ-012 The request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_src SHALL be captured on that edge.
REQ-013 The FSM SHALL have exactly three states: IDLE (req_ready=1), SEARCH, RESP (resp_valid=1); req_ready SHALL be 0 outside IDLE.
REQ-014 2x2 switch model: bit=0 passes (o1=i1, o2=i2); bit=1 swaps (o1=i2, o2=i1).
REQ-015 Network model: sw0(in1,in2)->t1,t2; sw3(in3,in4)->t4,t6; sw2(t2,t4)->t3,t5; sw1(t1,t3)->out1,out2; sw4(t5,t6)->out3,out4; switch k is driven by control[k].
REQ-016 On acceptance, if req_src has duplicate entries, the FSM SHALL go IDLE->RESP with resp_err=1, control unchanged.
REQ-017 Otherwise the FSM SHALL go IDLE->SEARCH with a 5-bit candidate counter at 0.
REQ-018 SEARCH SHALL evaluate one candidate per cycle in ascending order 0..31.
REQ-019 On the first match, the candidate SHALL be registered into control with resp_err=0 and the FSM SHALL go to RESP; latency for matching candidate k is k+1 cycles from the accept edge.
REQ-020 If candidate 31 does not match, the FSM SHALL go to RESP with resp_err=1 and control unchanged (latency 32).
REQ-021 RESP SHALL hold resp_valid, resp_err and control stable until an edge with resp_ready=1, then return to IDLE.
REQ-022 control SHALL change only on a successful result and SHALL otherwise hold its last value.
REQ-023 req_valid and req_src SHALL be ignored outside IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, control=5'b00000, and counter=0.
REQ-025 Reset asserted during SEARCH or RESP SHALL abort the operation with no result delivered.

Configuration
REQ-026 Macro XBAR_ROUTE_CTRL_CACHE_EN SHALL add a one-entry cache holding the last successfully routed req_src and its control word.
REQ-027 With XBAR_ROUTE_CTRL_CACHE_EN defined, an accepted request equal to a valid cache entry SHALL go IDLE->RESP with the cached control and resp_err=0 (latency 1); reset and error responses leave the cache invalid or unchanged respectively, and a success updates it.
REQ-028 With XBAR_ROUTE_CTRL_CACHE_EN undefined, no cache logic SHALL exist and every valid request SHALL search.

Verification
REQ-029 Identity: req_src=8'hE4 -> resp_valid 1 cycle after accept, control=5'h00, resp_err=0.
REQ-030 Swap out1/out2: req_src=8'hE1 -> control=5'h01, resp_err=0, latency 2.
REQ-031 Duplicate sources: req_src=8'h00 -> resp_err=1 after 1 cycle, control keeps its previous value.
REQ-032 Unroutable: req_src=8'h4E (out1=in3, out2=in4) -> resp_err=1 after exactly 32 cycles.
REQ-033 Backpressure and reset: hold resp_ready=0 for 5 cycles -> outputs stable, req_ready=0; assert rst_n=0 mid-SEARCH -> all outputs at reset values immediately, and the next request is served normally.
REQ-034 With XBAR_ROUTE_CTRL_CACHE_EN defined: send 8'hE1 twice -> second response after 1 cycle with control=5'h01.
